// File: rtl/sid_pkg.sv
// Shared constants for the SID-style synthesiser: voice, filter and audio output widths.
package sid_pkg;

   localparam int unsigned NUM_VOICES      = 3;
   localparam int unsigned VOICE_FREQ_W    = 16;
   localparam int unsigned VOICE_ACC_W     = 24;
   localparam int unsigned VOICE_PW_W      = 12;
   localparam int unsigned VOICE_ENV_W     = 8;

   localparam int unsigned FILTER_CUTOFF_W = 11;
   localparam int unsigned FILTER_RES_W    = 4;
   localparam int unsigned FILTER_DATA_W   = 16;

   localparam int unsigned PWM_SAMPLE_W    = 12;
   localparam int unsigned PWM_CNT_W       = 8;
   localparam int unsigned PWM_FRAC_W      = PWM_SAMPLE_W - PWM_CNT_W;

endpackage

// File: rtl/pwm_audio_out.sv
// Error-feedback PWM DAC: mixer samples are quantised to PWM_W bits once per
// period, and the discarded fraction is carried into the next period.
module pwm_audio_out
   import sid_pkg::*;
#(
   parameter int unsigned SAMPLE_W = PWM_SAMPLE_W,
   parameter int unsigned PWM_W    = PWM_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                clr_ovr,
   output logic                sample_ready,
   output logic                pwm_out,
   output logic                frame_start,
   output logic                overrun
);

   localparam int unsigned FRAC_W = SAMPLE_W - PWM_W;

   logic [PWM_W-1:0]    cnt_q, cnt_d;
   logic [PWM_W-1:0]    duty_q, duty_d;
   logic [FRAC_W-1:0]   err_q, err_d;
   logic [SAMPLE_W-1:0] active_q, active_d;
   logic [SAMPLE_W-1:0] hold_q, hold_d;
   logic                full_q, full_d;
   logic                run_q, run_d;
   logic                pwm_q, pwm_d;
   logic                fs_q, fs_d;
   logic                ovr_q, ovr_d;
   logic                rdy_q, rdy_d;

   logic                start;
   logic [SAMPLE_W-1:0] src;
   logic [SAMPLE_W:0]   sum;

   always_comb begin
      // A period starts on the wrap cycle, or on the first enabled clock after idle/reset.
      start    = en && (!run_q || (cnt_q == '1));
      src      = full_q ? hold_q : active_q;
      sum      = {1'b0, src} + {{(PWM_W + 1){1'b0}}, err_q};

      cnt_d    = cnt_q;
      duty_d   = duty_q;
      err_d    = err_q;
      active_d = active_q;
      hold_d   = hold_q;
      full_d   = full_q;
      run_d    = run_q;
      fs_d     = 1'b0;
      ovr_d    = ovr_q;

      if (!en) begin
         cnt_d = '0;
         err_d = '0;
         run_d = 1'b0;
      end else if (start) begin
         cnt_d    = '0;
         run_d    = 1'b1;
         fs_d     = 1'b1;
         active_d = src;
         full_d   = 1'b0;
         if (sum[SAMPLE_W]) begin
            duty_d = '1;
            err_d  = '0;
         end else begin
            duty_d = sum[SAMPLE_W-1:FRAC_W];
            err_d  = sum[FRAC_W-1:0];
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      if (clr_ovr) begin
         ovr_d = 1'b0;
      end
      // A strobe on the start cycle lands behind the transfer, so it is never an overrun.
      if (sample_valid) begin
         if (full_q && !start) begin
            ovr_d = 1'b1;
         end
         hold_d = sample_in;
         full_d = 1'b1;
      end

      pwm_d = en && (cnt_d < duty_d);
      rdy_d = !full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         duty_q   <= '0;
         err_q    <= '0;
         active_q <= '0;
         hold_q   <= '0;
         full_q   <= 1'b0;
         run_q    <= 1'b0;
         pwm_q    <= 1'b0;
         fs_q     <= 1'b0;
         ovr_q    <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         err_q    <= err_d;
         active_q <= active_d;
         hold_q   <= hold_d;
         full_q   <= full_d;
         run_q    <= run_d;
         pwm_q    <= pwm_d;
         fs_q     <= fs_d;
         ovr_q    <= ovr_d;
         rdy_q    <= rdy_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign frame_start  = fs_q;
   assign overrun      = ovr_q;
   assign sample_ready = rdy_q;

endmodule
